opcode_encoder: RTL and testbench

OPCODE_ENCODER -- requirements
Module: opcode_encoder

---
 rtl/opcode_encoder_pkg.sv | 40 ++++
 rtl/opcode_encoder_if.sv | 25 ++
 rtl/opcode_fifo.sv | 72 +++++++
 rtl/opcode_encoder.sv | 47 ++++
 tb/tb_opcode_encoder.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/opcode_encoder_pkg.sv
// Opcode constants and the internal-to-external encode mapping shared by the
// opcode encoder and the opcode decoder.
package opcode_encoder_pkg;

  typedef logic [2:0] opcode_t;

  localparam opcode_t INT_OP0 = 3'b000;
  localparam opcode_t INT_OP1 = 3'b001;
  localparam opcode_t INT_OP2 = 3'b010;
  localparam opcode_t INT_OP3 = 3'b011;
  localparam opcode_t INT_OP4 = 3'b100;
  localparam opcode_t INT_OP5 = 3'b101;
  localparam opcode_t INT_OP6 = 3'b110;
  localparam opcode_t INT_OP7 = 3'b111;

  localparam opcode_t EXT_OP0 = 3'b000;
  localparam opcode_t EXT_OP1 = 3'b011;
  localparam opcode_t EXT_OP2 = 3'b010;
  localparam opcode_t EXT_OP3 = 3'b001;
  localparam opcode_t EXT_OP4 = 3'b110;
  localparam opcode_t EXT_OP5 = 3'b101;
  localparam opcode_t EXT_OP6 = 3'b111;
  localparam opcode_t EXT_OP7 = 3'b100;

  function automatic opcode_t encode_op(opcode_t op);
    opcode_t ext;
    case (op)
      INT_OP1: ext = EXT_OP1;
      INT_OP2: ext = EXT_OP2;
      INT_OP3: ext = EXT_OP3;
      INT_OP4: ext = EXT_OP4;
      INT_OP5: ext = EXT_OP5;
      INT_OP6: ext = EXT_OP6;
      INT_OP7: ext = EXT_OP7;
      default: ext = EXT_OP0;
    endcase
    return ext;
  endfunction

endpackage

// File: rtl/opcode_encoder_if.sv
// Producer/consumer bus of the opcode encoder. Both sides use valid/ready:
// a beat transfers on a rising edge where valid and ready are both 1.
interface opcode_encoder_if #(parameter int DEPTH = 4);
  import opcode_encoder_pkg::*;

  logic                     in_valid;
  logic                     in_ready;
  opcode_t                  opcode_in;
  logic                     out_valid;
  logic                     out_ready;
  opcode_t                  opcode_out;
  logic [$clog2(DEPTH):0]   count;
  logic                     overflow_err;

  modport master (
    output in_valid, opcode_in, out_ready,
    input  in_ready, out_valid, opcode_out, count, overflow_err
  );

  modport slave (
    input  in_valid, opcode_in, out_ready,
    output in_ready, out_valid, opcode_out, count, overflow_err
  );

endinterface

// File: rtl/opcode_fifo.sv
// DEPTH-entry FIFO of 3-bit opcodes; head is shown from registers and forced
// to zero while empty.
module opcode_fifo
  import opcode_encoder_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  opcode_t          wdata_i,
  output opcode_t          rdata_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  opcode_t          mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = next_ptr(wr_ptr_q);
    if (do_pop)  rd_ptr_d = next_ptr(rd_ptr_q);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately not reset; stale entries are masked by count.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/opcode_encoder.sv
// Encodes internal opcodes to the external instruction format at push time
// and buffers them in order; flags any push attempted while full.
module opcode_encoder
  import opcode_encoder_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  opcode_encoder_if.slave   bus
);

  logic    full, empty;
  logic    push, pop;
  logic    overflow_q, overflow_d;
  opcode_t enc_op;

  assign enc_op = encode_op(bus.opcode_in);

  assign bus.in_ready  = !full;
  assign bus.out_valid = !empty;
  assign push          = bus.in_valid && !full;
  assign pop           = bus.out_ready && !empty;

  // A dropped push (valid while full) latches the error until reset.
  assign overflow_d = overflow_q || (bus.in_valid && full);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) overflow_q <= 1'b0;
    else     overflow_q <= overflow_d;
  end

  assign bus.overflow_err = overflow_q;

  opcode_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (enc_op),
    .rdata_o (bus.opcode_out),
    .count_o (bus.count),
    .full_o  (full),
    .empty_o (empty)
  );

endmodule

// File: tb/tb_opcode_encoder.sv
// Bench for opcode_encoder: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then random traffic.
module tb_opcode_encoder;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   cmp_en  = 1'b0;

  opcode_encoder_if #(.DEPTH(DEPTH)) bus();

  opcode_encoder #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: mapping table, queue of encoded entries, sticky error.
  logic [2:0] enc_tab [8] = '{3'b000, 3'b011, 3'b010, 3'b001,
                              3'b110, 3'b101, 3'b111, 3'b100};
  logic [2:0] exp_q [$];
  bit         exp_ovf;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      exp_ovf = 1'b0;
    end else begin
      int  sz;
      bit  do_push, do_pop;
      sz      = exp_q.size();
      do_push = bus.in_valid && (sz < DEPTH);
      do_pop  = bus.out_ready && (sz > 0);
      if (bus.in_valid && sz == DEPTH) exp_ovf = 1'b1;
      if (do_pop)  void'(exp_q.pop_front());
      if (do_push) exp_q.push_back(enc_tab[bus.opcode_in]);
    end
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      int sz;
      sz = exp_q.size();
      check("m_count",     32'(bus.count),        32'(sz));
      check("m_in_ready",  32'(bus.in_ready),     32'(sz < DEPTH));
      check("m_out_valid", 32'(bus.out_valid),    32'(sz != 0));
      check("m_opcode",    32'(bus.opcode_out),   32'((sz != 0) ? exp_q[0] : 3'b000));
      check("m_overflow",  32'(bus.overflow_err), 32'(exp_ovf));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(bit v, logic [2:0] op, bit rdy);
    bus.in_valid  = v;
    bus.opcode_in = op;
    bus.out_ready = rdy;
  endtask

  logic [2:0] got [8];
  logic [2:0] exp33 [8] = '{3'b000, 3'b011, 3'b010, 3'b001,
                            3'b110, 3'b101, 3'b111, 3'b100};
  logic [2:0] exp34 [4] = '{3'b011, 3'b010, 3'b001, 3'b110};

  initial begin
    drive(1'b0, 3'b000, 1'b0);
    rst = 1'b1;
    step();
    step();
    cmp_en = 1'b1;
    check("rst_count",     32'(bus.count),        32'd0);
    check("rst_in_ready",  32'(bus.in_ready),     32'd1);
    check("rst_out_valid", 32'(bus.out_valid),    32'd0);
    check("rst_opcode",    32'(bus.opcode_out),   32'd0);
    check("rst_overflow",  32'(bus.overflow_err), 32'd0);
    rst = 1'b0;
    step();

    // Single push, one-edge latency, then drains.
    drive(1'b1, 3'b001, 1'b1);
    step();
    drive(1'b0, 3'b000, 1'b1);
    check("single_valid",  32'(bus.out_valid),  32'd1);
    check("single_opcode", 32'(bus.opcode_out), 32'h3);
    step();
    check("single_empty",  32'(bus.out_valid),  32'd0);

    // All eight codes back-to-back.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 3'(i), 1'b1);
      step();
      got[i] = bus.opcode_out;
    end
    drive(1'b0, 3'b000, 1'b1);
    step();
    for (int i = 0; i < 8; i++) check($sformatf("seq8_%0d", i), 32'(got[i]), 32'(exp33[i]));
    check("seq8_drained", 32'(bus.count), 32'd0);

    // Overflow: five pushes into a four-entry buffer with no consumer.
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 3'(i), 1'b0);
      step();
      if (i == 4) begin
        check("ovf_count4", 32'(bus.count),        32'd4);
        check("ovf_ready0", 32'(bus.in_ready),     32'd0);
        check("ovf_flag0",  32'(bus.overflow_err), 32'd0);
      end
    end
    check("ovf_flag1", 32'(bus.overflow_err), 32'd1);
    drive(1'b0, 3'b000, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("ovf_drain_%0d", i), 32'(bus.opcode_out), 32'(exp34[i]));
      step();
    end
    check("ovf_empty",  32'(bus.count),        32'd0);
    check("ovf_sticky", 32'(bus.overflow_err), 32'd1);

    // Full buffer with producer and consumer both active.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 3'($urandom_range(0, 7)), 1'b0);
      step();
    end
    drive(1'b1, 3'($urandom_range(0, 7)), 1'b1);
    check("full_ready0", 32'(bus.in_ready), 32'd0);
    step();
    check("full_after_pop", 32'(bus.count), 32'd3);
    for (int i = 1; i < 8; i++) begin
      drive(1'b1, 3'($urandom_range(0, 7)), 1'b1);
      step();
      check("full_bound", 32'(bus.count <= 3'd4), 32'd1);
    end

    // Steady state at two entries with pointer wrap.
    drive(1'b0, 3'b000, 1'b1);
    repeat (4) step();
    drive(1'b1, 3'b110, 1'b0);
    step();
    drive(1'b1, 3'b111, 1'b0);
    step();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 3'($urandom_range(0, 7)), 1'b1);
      step();
    end
    check("steady_count2", 32'(bus.count), 32'd2);

    // Asynchronous reset mid-stream with three entries held.
    drive(1'b1, 3'b101, 1'b0);
    step();
    drive(1'b0, 3'b000, 1'b0);
    check("pre_rst_count3", 32'(bus.count), 32'd3);
    #2 rst = 1'b1;
    #1;
    check("arst_count",     32'(bus.count),        32'd0);
    check("arst_out_valid", 32'(bus.out_valid),    32'd0);
    check("arst_opcode",    32'(bus.opcode_out),   32'd0);
    check("arst_overflow",  32'(bus.overflow_err), 32'd0);
    check("arst_in_ready",  32'(bus.in_ready),     32'd1);
    step();
    rst = 1'b0;
    drive(1'b1, 3'b100, 1'b0);
    step();
    drive(1'b0, 3'b000, 1'b0);
    check("post_rst_head", 32'(bus.opcode_out), 32'h6);
    check("post_rst_count", 32'(bus.count), 32'd1);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
            1'($urandom_range(0, 99) < 40));
      step();
    end
    drive(1'b0, 3'b000, 1'b1);
    repeat (6) step();
    check("final_empty", 32'(bus.count), 32'd0);

    @(negedge clk);
    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
